// File: rtl/arinc_key_panel.sv
// -----------------------------------------------------------------------------
// arinc_key_panel
//
// Front-panel key controller for the ARINC429 link board. Four raw active-low
// keys are synchronised and debounced in the clk domain. Their press events
// edit an N-digit BCD-style word, toggle the TX/RX edit mode and the two
// bit-rate selects, and request a handshaked start strobe for the ARINC429
// transmitter.
//
// Optional feature macro:
//   AUTO_REPEAT_EN - when defined, holding key[1] produces repeated digit
//                    increments (first after RPT_DLY cycles, then every
//                    RPT_PER cycles). When undefined, there is no repeat
//                    logic and each debounced press gives exactly one event.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous reset, active-high (released synchronously)
//   key_i[3:0]    raw keys, active-low, asynchronous to clk_i
//                   [0] select next digit / send slot
//                   [1] increment selected digit, or request send
//                   [2] toggle TX/RX edit mode
//                   [3] toggle the rate select of the current mode
//   tx_busy_i     transmitter busy; the start strobe is held off while 1
//   dig_val_o     packed digits, digit i at [i*DIG_W +: DIG_W]
//   dig_sel_o     select position 0..NUM_DIG (NUM_DIG is the send slot)
//   start_o       one-cycle transmit strobe
//   start_pend_o  start requested, waiting for tx_busy_i to drop
//   txstate_o     0 = TX-rate edit mode, 1 = RX-rate edit mode
//   send_rate_o   TX bit-rate select
//   rec_rate_o    RX bit-rate select
// -----------------------------------------------------------------------------
module arinc_key_panel #(
    parameter int NUM_DIG = 6,
    parameter int DIG_W   = 4,
    parameter int DIG_MAX = 9,
    parameter int DEB_CYC = 500000,
    parameter int RPT_DLY = 25000000,
    parameter int RPT_PER = 5000000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [3:0]                 key_i,
    input  logic                       tx_busy_i,
    output logic [NUM_DIG*DIG_W-1:0]   dig_val_o,
    output logic [$clog2(NUM_DIG+1)-1:0] dig_sel_o,
    output logic                       start_o,
    output logic                       start_pend_o,
    output logic                       txstate_o,
    output logic                       send_rate_o,
    output logic                       rec_rate_o
);

    localparam int SEL_W = $clog2(NUM_DIG + 1);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

    // Start handshake states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Reset is asserted asynchronously but released on a clock edge, so every
    // register below leaves reset in the same cycle.
    logic [1:0] rstSync_q;
    logic       rstInt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rstSync_q <= 2'b11;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b0};
        end
    end

    assign rstInt = rstSync_q[1];

    // Two-flop synchronisers for the raw keys. They come out of reset at 1
    // (released). sampleValid_q tracks when the second stage holds a real
    // sample of the key pins rather than the reset value.
    logic [3:0] keySync1_q;
    logic [3:0] keySync2_q;
    logic [1:0] sampleValid_q;

    always_ff @(posedge clk_i or posedge rstInt) begin
        if (rstInt) begin
            keySync1_q    <= 4'hF;
            keySync2_q    <= 4'hF;
            sampleValid_q <= 2'b00;
        end else begin
            keySync1_q    <= key_i;
            keySync2_q    <= keySync1_q;
            sampleValid_q <= {sampleValid_q[0], 1'b1};
        end
    end

    // Debouncer: a counter runs while the synchronised level differs from the
    // accepted level and is cleared when they agree. After DEB_CYC differing
    // cycles the new level is accepted. A key is only "armed" once it has
    // really been seen released after reset, so a key held down across reset
    // cannot produce a press when reset lifts.
    logic [3:0]       debState_q;
    logic [3:0]       debState_d;
    logic [DEB_W-1:0] debCnt_q [4];
    logic [DEB_W-1:0] debCnt_d [4];
    logic [3:0]       armed_q;
    logic [3:0]       armed_d;
    logic [3:0]       pressEv;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            debState_d[k] = debState_q[k];
            debCnt_d[k]   = '0;
            if (keySync2_q[k] != debState_q[k]) begin
                if (debCnt_q[k] == DEB_W'(DEB_CYC - 1)) begin
                    debState_d[k] = keySync2_q[k];
                end else begin
                    debCnt_d[k] = debCnt_q[k] + DEB_W'(1);
                end
            end
            armed_d[k] = armed_q[k] | (sampleValid_q[1] & keySync2_q[k] & debState_q[k]);
            pressEv[k] = armed_q[k] & debState_q[k] & ~debState_d[k];
        end
    end

    always_ff @(posedge clk_i or posedge rstInt) begin
        if (rstInt) begin
            debState_q <= 4'hF;
            armed_q    <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                debCnt_q[k] <= '0;
            end
        end else begin
            debState_q <= debState_d;
            armed_q    <= armed_d;
            for (int k = 0; k < 4; k++) begin
                debCnt_q[k] <= debCnt_d[k];
            end
        end
    end

    // Auto-repeat for key[1]. The counter only runs while key[1] is held after
    // a genuine press; the first repeat waits RPT_DLY cycles, later ones
    // RPT_PER cycles.
    logic rptFire;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rptCnt_q;
    logic [RPT_W-1:0] rptCnt_d;
    logic             rptPhase_q;
    logic             rptPhase_d;

    always_comb begin
        rptCnt_d   = '0;
        rptPhase_d = 1'b0;
        rptFire    = 1'b0;
        if (!debState_q[1] && armed_q[1]) begin
            rptPhase_d = rptPhase_q;
            if (!rptPhase_q) begin
                if (rptCnt_q == RPT_W'(RPT_DLY - 1)) begin
                    rptFire    = 1'b1;
                    rptPhase_d = 1'b1;
                end else begin
                    rptCnt_d = rptCnt_q + RPT_W'(1);
                end
            end else begin
                if (rptCnt_q == RPT_W'(RPT_PER - 1)) begin
                    rptFire = 1'b1;
                end else begin
                    rptCnt_d = rptCnt_q + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rstInt) begin
        if (rstInt) begin
            rptCnt_q   <= '0;
            rptPhase_q <= 1'b0;
        end else begin
            rptCnt_q   <= rptCnt_d;
            rptPhase_q <= rptPhase_d;
        end
    end
`else
    // The repeat timing parameters only matter with repeat enabled; this
    // expression is constant zero for any legal setting.
    assign rptFire = (RPT_DLY < 0) && (RPT_PER < 0);
`endif

    // Panel registers
    logic [SEL_W-1:0]         digSel_q;
    logic [SEL_W-1:0]         digSel_d;
    logic [NUM_DIG*DIG_W-1:0] digVal_q;
    logic [NUM_DIG*DIG_W-1:0] digVal_d;
    logic                     txState_q;
    logic                     txState_d;
    logic                     sendRate_q;
    logic                     sendRate_d;
    logic                     recRate_q;
    logic                     recRate_d;
    logic [0:0]               state_q;
    logic [0:0]               state_d;
    logic                     start_q;
    logic                     start_d;

    logic onSendSlot;
    logic digInc;
    logic sendReq;
    logic [DIG_W-1:0] curDig;

    // All key actions look at the register values from before this edge, so
    // simultaneous presses never see each other's effect.
    assign onSendSlot = (digSel_q == SEL_W'(NUM_DIG));
    assign digInc     = (pressEv[1] | rptFire) & ~onSendSlot;
    assign sendReq    = pressEv[1] & onSendSlot;

    // Select position and mode/rate toggles
    always_comb begin
        digSel_d = digSel_q;
        if (pressEv[0]) begin
            digSel_d = onSendSlot ? '0 : digSel_q + SEL_W'(1);
        end
        txState_d  = txState_q ^ pressEv[2];
        sendRate_d = sendRate_q ^ (pressEv[3] & ~txState_q);
        recRate_d  = recRate_q ^ (pressEv[3] & txState_q);
    end

    // Increment the digit at the old select position, wrapping at DIG_MAX
    always_comb begin
        digVal_d = digVal_q;
        curDig   = '0;
        if (digInc) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (digSel_q == SEL_W'(i)) begin
                    curDig = digVal_q[i*DIG_W +: DIG_W];
                    digVal_d[i*DIG_W +: DIG_W] =
                        (curDig == DIG_W'(DIG_MAX)) ? '0 : curDig + DIG_W'(1);
                end
            end
        end
    end

    // Start handshake. A request while pending is absorbed; the strobe is
    // registered, so it appears the cycle after the request is seen with the
    // transmitter free.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sendReq) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!tx_busy_i) begin
                    start_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rstInt) begin
        if (rstInt) begin
            digSel_q   <= '0;
            digVal_q   <= '0;
            txState_q  <= 1'b0;
            sendRate_q <= 1'b0;
            recRate_q  <= 1'b0;
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
        end else begin
            digSel_q   <= digSel_d;
            digVal_q   <= digVal_d;
            txState_q  <= txState_d;
            sendRate_q <= sendRate_d;
            recRate_q  <= recRate_d;
            state_q    <= state_d;
            start_q    <= start_d;
        end
    end

    assign dig_val_o    = digVal_q;
    assign dig_sel_o    = digSel_q;
    assign start_o      = start_q;
    assign start_pend_o = (state_q == ST_PEND);
    assign txstate_o    = txState_q;
    assign send_rate_o  = sendRate_q;
    assign rec_rate_o   = recRate_q;

endmodule

// File: tb/tb_arinc_key_panel.sv
// -----------------------------------------------------------------------------
// tb_arinc_key_panel
//
// Self-checking bench for arinc_key_panel with short debounce/repeat timing.
// A hand-derived vector table walks through select wrap, digit wrap, the start
// handshake and same-cycle presses; a randomized phase is checked against a
// press-level reference model; hand sequences cover the glitch filter,
// auto-repeat timing and reset while a key is held.
// -----------------------------------------------------------------------------
module tb_arinc_key_panel;

    localparam int NUM_DIG = 6;
    localparam int DIG_W   = 4;
    localparam int DIG_MAX = 9;
    localparam int DEB_CYC = 4;
    localparam int RPT_DLY = 20;
    localparam int RPT_PER = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        txBusy;
    logic [NUM_DIG*DIG_W-1:0] digVal;
    logic [2:0]  digSel;
    logic        startPulse;
    logic        startPend;
    logic        txState;
    logic        sendRate;
    logic        recRate;

    int checks   = 0;
    int failures = 0;
    int startCount = 0;

    // Reference model state, updated once per press
    int mSel;
    int mDig [NUM_DIG];
    bit mPend;
    bit mTx;
    bit mSend;
    bit mRec;
    int mStarts;

    typedef struct {
        logic [3:0]  mask;
        bit          busy;
        int          expSel;
        logic [23:0] expVal;
        bit          expPend;
        bit          expTx;
        bit          expSend;
        bit          expRec;
        int          expStarts;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    arinc_key_panel #(
        .NUM_DIG(NUM_DIG),
        .DIG_W  (DIG_W),
        .DIG_MAX(DIG_MAX),
        .DEB_CYC(DEB_CYC),
        .RPT_DLY(RPT_DLY),
        .RPT_PER(RPT_PER)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_i       (key),
        .tx_busy_i   (txBusy),
        .dig_val_o   (digVal),
        .dig_sel_o   (digSel),
        .start_o     (startPulse),
        .start_pend_o(startPend),
        .txstate_o   (txState),
        .send_rate_o (sendRate),
        .rec_rate_o  (recRate)
    );

    // Count every cycle the start strobe is high
    always @(posedge clk) begin
        if (startPulse) startCount <= startCount + 1;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press the keys in mask together long enough to be accepted, then release
    task automatic applyStimulus(input logic [3:0] mask, input bit busy);
        txBusy = busy;
        key    = ~mask;
        waitCycles(DEB_CYC + 3);
        key    = 4'hF;
        waitCycles(DEB_CYC + 6);
    endtask

    task automatic doReset();
        rst = 1'b1;
        waitCycles(3);
        startCount = 0;
        rst = 1'b0;
        waitCycles(6);
    endtask

    task automatic addVec(input logic [3:0] mask, input bit busy, input int sel,
                          input logic [23:0] val, input bit pend, input bit tx,
                          input bit snd, input bit rec, input int starts);
        vec_t v;
        v.mask = mask; v.busy = busy; v.expSel = sel; v.expVal = val;
        v.expPend = pend; v.expTx = tx; v.expSend = snd; v.expRec = rec;
        v.expStarts = starts;
        vecs.push_back(v);
    endtask

    function automatic logic [23:0] modelDigits();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIG; i++) r = r | (24'(mDig[i]) << (i * DIG_W));
        return r;
    endfunction

    function automatic void modelReset();
        mSel = 0; mPend = 0; mTx = 0; mSend = 0; mRec = 0; mStarts = 0;
        for (int i = 0; i < NUM_DIG; i++) mDig[i] = 0;
    endfunction

    // One press of the keys in mask with tx busy level held at busy
    function automatic void modelStep(input logic [3:0] mask, input bit busy);
        int oSel;
        bit oTx;
        if (mPend && !busy) begin mStarts++; mPend = 0; end
        oSel = mSel;
        oTx  = mTx;
        if (mask[0]) mSel = (oSel == NUM_DIG) ? 0 : oSel + 1;
        if (mask[1]) begin
            if (oSel < NUM_DIG) mDig[oSel] = (mDig[oSel] + 1) % (DIG_MAX + 1);
            else mPend = 1;
        end
        if (mask[2]) mTx = !oTx;
        if (mask[3]) begin
            if (oTx) mRec = !mRec;
            else mSend = !mSend;
        end
        if (mPend && !busy) begin mStarts++; mPend = 0; end
    endfunction

    initial begin
        logic [3:0] rmask;
        bit         rbusy;
        vec_t       v;
        string      tag;

        // Hand-derived vectors, applied in order from reset
        addVec(4'b0001, 0, 1, 24'h0, 0, 0, 0, 0, 0);
        addVec(4'b0001, 0, 2, 24'h0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            addVec(4'b0010, 0, 2, 24'((k % 10) << 8), 0, 0, 0, 0, 0);
        for (int s = 3; s <= 6; s++)
            addVec(4'b0001, 0, s, 24'h0, 0, 0, 0, 0, 0);
        addVec(4'b0001, 0, 0, 24'h0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 6; s++)
            addVec(4'b0001, 0, s, 24'h0, 0, 0, 0, 0, 0);
        addVec(4'b0010, 1, 6, 24'h0, 1, 0, 0, 0, 0);
        addVec(4'b0010, 1, 6, 24'h0, 1, 0, 0, 0, 0);
        addVec(4'b0000, 0, 6, 24'h0, 0, 0, 0, 0, 1);
        addVec(4'b0010, 0, 6, 24'h0, 0, 0, 0, 0, 2);
        addVec(4'b1100, 0, 6, 24'h0, 0, 1, 1, 0, 2);
        addVec(4'b1000, 0, 6, 24'h0, 0, 1, 1, 1, 2);
        addVec(4'b0100, 0, 6, 24'h0, 0, 0, 1, 1, 2);
        addVec(4'b1000, 0, 6, 24'h0, 0, 0, 0, 1, 2);
        addVec(4'b0010, 1, 6, 24'h0, 1, 0, 0, 1, 2);
        addVec(4'b0001, 1, 0, 24'h0, 1, 0, 0, 1, 2);
        addVec(4'b0000, 0, 0, 24'h0, 0, 0, 0, 1, 3);
        addVec(4'b0011, 0, 1, 24'h1, 0, 0, 0, 1, 3);
        addVec(4'b0011, 0, 2, 24'h11, 0, 0, 0, 1, 3);
        addVec(4'b1110, 0, 2, 24'h111, 0, 1, 1, 1, 3);

        key    = 4'hF;
        txBusy = 1'b0;
        rst    = 1'b1;
        waitCycles(2);
        checkOutput("reset_outputs", {digVal, 3'(digSel), startPulse, startPend, txState, sendRate, recRate}, 0);
        doReset();
        checkOutput("post_reset_outputs", {digVal, 3'(digSel), startPulse, startPend, txState, sendRate, recRate}, 0);

        // Short glitch must be filtered out
        key = 4'b1101;
        waitCycles(3);
        key = 4'hF;
        waitCycles(12);
        checkOutput("glitch_dig_val", digVal, 0);
        checkOutput("glitch_dig_sel", digSel, 0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.mask, v.busy);
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, "_sel"},    digSel,     v.expSel);
            checkOutput({tag, "_val"},    digVal,     v.expVal);
            checkOutput({tag, "_pend"},   startPend,  v.expPend);
            checkOutput({tag, "_tx"},     txState,    v.expTx);
            checkOutput({tag, "_send"},   sendRate,   v.expSend);
            checkOutput({tag, "_rec"},    recRate,    v.expRec);
            checkOutput({tag, "_starts"}, startCount, v.expStarts);
        end

        // Randomized presses against the reference model
        doReset();
        modelReset();
        for (int i = 0; i < 50; i++) begin
            rmask = 4'($urandom_range(0, 15));
            rbusy = 1'($urandom_range(0, 1));
            applyStimulus(rmask, rbusy);
            modelStep(rmask, rbusy);
            tag = $sformatf("rnd%0d", i);
            checkOutput({tag, "_sel"},    digSel,     mSel);
            checkOutput({tag, "_val"},    digVal,     modelDigits());
            checkOutput({tag, "_pend"},   startPend,  mPend);
            checkOutput({tag, "_tx"},     txState,    mTx);
            checkOutput({tag, "_send"},   sendRate,   mSend);
            checkOutput({tag, "_rec"},    recRate,    mRec);
            checkOutput({tag, "_starts"}, startCount, mStarts);
        end

        // Hold key[1] and track repeat timing relative to the press event
        txBusy = 1'b0;
        doReset();
        key = 4'b1101;
        waitCycles(DEB_CYC + 1);
        checkOutput("hold_before_event", digVal, 0);
        waitCycles(1);
        checkOutput("hold_first_event", digVal, 1);
        waitCycles(RPT_DLY - 1);
        checkOutput("hold_before_rpt1", digVal, 1);
        waitCycles(1);
`ifdef AUTO_REPEAT_EN
        checkOutput("hold_rpt1", digVal, 2);
`else
        checkOutput("hold_no_rpt1", digVal, 1);
`endif
        waitCycles(RPT_PER);
`ifdef AUTO_REPEAT_EN
        checkOutput("hold_rpt2", digVal, 3);
`else
        checkOutput("hold_no_rpt2", digVal, 1);
`endif

        // Reset while the key is still held: everything clears at once and
        // the held key does not count as a fresh press
        rst = 1'b1;
        #1;
        checkOutput("rst_held_async", {digVal, 3'(digSel), startPulse, startPend, txState, sendRate, recRate}, 0);
        waitCycles(3);
        startCount = 0;
        rst = 1'b0;
        waitCycles(40);
        checkOutput("rst_held_no_event", digVal, 0);
        key = 4'hF;
        waitCycles(12);
        checkOutput("rst_release_no_event", digVal, 0);
        checkOutput("rst_no_start", startCount, 0);
        applyStimulus(4'b0010, 0);
        checkOutput("rearm_press", digVal, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
